// File: rtl/raid_host_arbiter.sv
// Round-robin arbiter sharing the RAID controller host port among NREQ requesters.
// One transaction in flight; sequences enable pulse, busy rise/fall, settle and capture.
module raid_host_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned TO_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_we,
  input  logic [32*NREQ-1:0]   req_addr,
  input  logic [32*NREQ-1:0]   req_din,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      ack,
  output logic [31:0]          rsp_data,
  output logic                 rsp_parity,
  output logic                 rsp_err,
  output logic                 rsp_timeout,
  output logic                 raid_read_en,
  output logic                 raid_write_en,
  output logic [31:0]          raid_addr,
  output logic [31:0]          raid_din,
  input  logic [31:0]          raid_dout,
  input  logic                 raid_busy,
  input  logic                 raid_parity,
  input  logic                 raid_err
);

  localparam int unsigned PtrW = $clog2(NREQ);
  localparam int unsigned CntW = $clog2(TO_CYCLES + 1);

  typedef enum logic [2:0] {StIdle, StIssue, StStart, StRun, StSettle, StDone} state_e;

  state_e          state_q, state_d;
  logic [PtrW-1:0] ptr_q, ptr_d, gidx_q, gidx_d, sel_idx;
  logic            sel_found;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            to_q, to_d;
  logic [NREQ-1:0] grant_q, grant_d, ack_q, ack_d;
  logic            rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [31:0]     addr_q, addr_d, din_q, din_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic            rsp_parity_q, rsp_parity_d, rsp_err_q, rsp_err_d, rsp_to_q, rsp_to_d;
  logic [31:0]     addr_arr [NREQ];
  logic [31:0]     din_arr  [NREQ];

  for (genvar i = 0; i < int'(NREQ); i++) begin : g_unpack
    assign addr_arr[i] = req_addr[32*i +: 32];
    assign din_arr[i]  = req_din[32*i +: 32];
  end

  // First requester at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    int          idx;
    logic [PtrW-1:0] idx_w;
    sel_idx   = '0;
    sel_found = 1'b0;
    idx       = 0;
    idx_w     = '0;
    for (int off = 0; off < int'(NREQ); off++) begin
      idx = int'(ptr_q) + off;
      if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
      idx_w = PtrW'(idx);
      if (!sel_found && req[idx_w]) begin
        sel_found = 1'b1;
        sel_idx   = idx_w;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gidx_d       = gidx_q;
    cnt_d        = cnt_q;
    to_d         = to_q;
    grant_d      = grant_q;
    ack_d        = '0;
    rd_en_d      = 1'b0;
    wr_en_d      = 1'b0;
    addr_d       = addr_q;
    din_d        = din_q;
    rsp_data_d   = rsp_data_q;
    rsp_parity_d = rsp_parity_q;
    rsp_err_d    = rsp_err_q;
    rsp_to_d     = rsp_to_q;
    cnt_inc      = cnt_q + 1'b1;
    unique case (state_q)
      StIdle: begin
        if (sel_found && !raid_busy) begin
          state_d = StIssue;
          gidx_d  = sel_idx;
          grant_d = NREQ'(1) << sel_idx;
          addr_d  = addr_arr[sel_idx];
          din_d   = din_arr[sel_idx];
          // Enables are registered so they are high exactly during StIssue.
          wr_en_d = req_we[sel_idx];
          rd_en_d = !req_we[sel_idx];
        end
      end
      StIssue: begin
        cnt_d   = '0;
        to_d    = 1'b0;
        state_d = StStart;
      end
      StStart: begin
        if (raid_busy) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CntW'(TO_CYCLES - 1)) begin
            to_d    = 1'b1;
            state_d = StDone;
          end
        end
      end
      StRun: begin
        if (!raid_busy) state_d = StSettle;
      end
      StSettle: state_d = StDone;
      StDone: begin
        rsp_data_d   = raid_dout;
        rsp_parity_d = raid_parity;
        rsp_err_d    = raid_err;
        rsp_to_d     = to_q;
        ack_d        = grant_q;
        grant_d      = '0;
        ptr_d        = (gidx_q == PtrW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      gidx_q       <= '0;
      cnt_q        <= '0;
      to_q         <= 1'b0;
      grant_q      <= '0;
      ack_q        <= '0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      addr_q       <= '0;
      din_q        <= '0;
      rsp_data_q   <= '0;
      rsp_parity_q <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_to_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gidx_q       <= gidx_d;
      cnt_q        <= cnt_d;
      to_q         <= to_d;
      grant_q      <= grant_d;
      ack_q        <= ack_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      rsp_data_q   <= rsp_data_d;
      rsp_parity_q <= rsp_parity_d;
      rsp_err_q    <= rsp_err_d;
      rsp_to_q     <= rsp_to_d;
    end
  end

  assign grant         = grant_q;
  assign ack           = ack_q;
  assign raid_read_en  = rd_en_q;
  assign raid_write_en = wr_en_q;
  assign raid_addr     = addr_q;
  assign raid_din      = din_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_parity    = rsp_parity_q;
  assign rsp_err       = rsp_err_q;
  assign rsp_timeout   = rsp_to_q;

endmodule

// File: tb/tb_raid_host_arbiter.sv
// Directed bench for raid_host_arbiter with a simple busy-pulse controller model.
module tb_raid_host_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req, req_we;
  logic [127:0] req_addr, req_din;
  logic [3:0]   grant, ack;
  logic [31:0]  rsp_data;
  logic         rsp_parity, rsp_err, rsp_timeout;
  logic         raid_read_en, raid_write_en;
  logic [31:0]  raid_addr, raid_din;
  logic [31:0]  raid_dout;
  logic         raid_busy, raid_parity, raid_err;

  int  passed = 0;
  int  total  = 0;
  int  busy_len = 3;
  int  busy_cnt = 0;
  bit  model_on = 1'b1;
  bit  force_busy = 1'b0;
  int  rd_cnt = 0, wr_cnt = 0, ovl_cnt = 0;

  raid_host_arbiter #(.NREQ(4), .TO_CYCLES(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_din      (req_din),
    .grant        (grant),
    .ack          (ack),
    .rsp_data     (rsp_data),
    .rsp_parity   (rsp_parity),
    .rsp_err      (rsp_err),
    .rsp_timeout  (rsp_timeout),
    .raid_read_en (raid_read_en),
    .raid_write_en(raid_write_en),
    .raid_addr    (raid_addr),
    .raid_din     (raid_din),
    .raid_dout    (raid_dout),
    .raid_busy    (raid_busy),
    .raid_parity  (raid_parity),
    .raid_err     (raid_err)
  );

  always #5 clk = ~clk;

  // Controller model: busy rises the cycle after an enable and stays high busy_len cycles.
  always @(posedge clk) begin
    if (model_on && (raid_read_en || raid_write_en)) busy_cnt <= busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign raid_busy = force_busy || (busy_cnt != 0);

  always @(negedge clk) begin
    if (!reset) begin
      if (raid_read_en) rd_cnt <= rd_cnt + 1;
      if (raid_write_en) wr_cnt <= wr_cnt + 1;
      if (raid_read_en && raid_write_en) ovl_cnt <= ovl_cnt + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wait_grant(input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (grant == 4'b0 && n < max);
  endtask

  task automatic wait_ack(input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (ack == 4'b0 && n < max);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int n, rd0, wr0, early;
    logic [3:0] exp_g;
    reset       = 1'b1;
    req         = 4'b0;
    req_we      = 4'b0;
    req_addr    = {32'h300, 32'h200, 32'h10, 32'h100};
    req_din     = {32'h33, 32'h22, 32'h11, 32'h0102_0304};
    raid_dout   = 32'hA5A5_0001;
    raid_parity = 1'b0;
    raid_err    = 1'b0;
    step();
    step();
    check("rst_grant", 32'(grant), 32'b0);
    check("rst_ack", 32'(ack), 32'b0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_rd_en", 32'(raid_read_en), 32'd0);
    check("rst_wr_en", 32'(raid_write_en), 32'd0);
    check("rst_addr", raid_addr, 32'h0);
    reset = 1'b0;

    // Single read from requester 1, busy high 3 cycles.
    rd0 = rd_cnt; wr0 = wr_cnt;
    busy_len = 3;
    req = 4'b0010;
    wait_grant(5, n);
    check("t1_grant_lat", 32'(n), 32'd1);
    check("t1_grant", 32'(grant), 32'b0010);
    check("t1_rd_en", 32'(raid_read_en), 32'd1);
    check("t1_wr_en", 32'(raid_write_en), 32'd0);
    check("t1_addr", raid_addr, 32'h10);
    wait_ack(20, n);
    req = 4'b0;
    check("t1_ack_lat", 32'(n), 32'd7);
    check("t1_ack", 32'(ack), 32'b0010);
    check("t1_data", rsp_data, 32'hA5A5_0001);
    check("t1_timeout", 32'(rsp_timeout), 32'd0);
    check("t1_grant_clr", 32'(grant), 32'b0);
    step();
    check("t1_ack_pulse", 32'(ack), 32'b0);
    check("t1_data_hold", rsp_data, 32'hA5A5_0001);
    check("t1_rd_pulses", 32'(rd_cnt - rd0), 32'd1);
    check("t1_wr_pulses", 32'(wr_cnt - wr0), 32'd0);

    // Single write from requester 0 with parity/err flags set.
    rd0 = rd_cnt; wr0 = wr_cnt;
    busy_len = 2;
    raid_dout = 32'hDEAD_BEEF;
    raid_parity = 1'b1;
    raid_err = 1'b1;
    req_we = 4'b0001;
    req = 4'b0001;
    wait_grant(5, n);
    check("t2_grant", 32'(grant), 32'b0001);
    check("t2_wr_en", 32'(raid_write_en), 32'd1);
    check("t2_rd_en", 32'(raid_read_en), 32'd0);
    check("t2_din", raid_din, 32'h0102_0304);
    wait_ack(20, n);
    req = 4'b0;
    req_we = 4'b0;
    check("t2_ack_lat", 32'(n), 32'd6);
    check("t2_ack", 32'(ack), 32'b0001);
    check("t2_addr_stable", raid_addr, 32'h100);
    check("t2_parity", 32'(rsp_parity), 32'd1);
    check("t2_err", 32'(rsp_err), 32'd1);
    check("t2_wr_pulses", 32'(wr_cnt - wr0), 32'd1);
    check("t2_rd_pulses", 32'(rd_cnt - rd0), 32'd0);
    raid_parity = 1'b0;
    raid_err = 1'b0;

    // Round robin with all four requesting continuously.
    do_reset();
    rd0 = rd_cnt;
    busy_len = 2;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      wait_grant(5, n);
      check("t3_grant", 32'(grant), 32'(exp_g));
      wait_ack(20, n);
      check("t3_ack", 32'(ack), 32'(exp_g));
    end
    req = 4'b0;
    check("t3_rd_pulses", 32'(rd_cnt - rd0), 32'd5);

    // Controller busy for 10 cycles after reset release.
    force_busy = 1'b1;
    req = 4'b0001;
    do_reset();
    early = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (grant != 4'b0) early++;
    end
    check("t4_no_grant", 32'(early), 32'd0);
    force_busy = 1'b0;
    wait_grant(5, n);
    check("t4_grant_lat", 32'(n), 32'd1);
    check("t4_grant", 32'(grant), 32'b0001);
    check("t4_rd_en", 32'(raid_read_en), 32'd1);
    wait_ack(20, n);
    req = 4'b0;
    check("t4_ack", 32'(ack), 32'b0001);
    check("t4_ack_lat", 32'(n), 32'd6);

    // Start timeout on requester 0, then requester 1 served normally.
    do_reset();
    model_on = 1'b0;
    req = 4'b0011;
    wait_grant(5, n);
    check("t5_grant", 32'(grant), 32'b0001);
    wait_ack(100, n);
    req = 4'b0010;
    model_on = 1'b1;
    check("t5_ack_lat", 32'(n), 32'd65);
    check("t5_ack", 32'(ack), 32'b0001);
    check("t5_timeout", 32'(rsp_timeout), 32'd1);
    wait_grant(5, n);
    check("t5_next_grant", 32'(grant), 32'b0010);
    wait_ack(20, n);
    req = 4'b0;
    check("t5_next_ack", 32'(ack), 32'b0010);
    check("t5_timeout_clr", 32'(rsp_timeout), 32'd0);

    // Reset while the controller is busy; pointer must restart at 0.
    busy_len = 6;
    req = 4'b0100;
    wait_grant(5, n);
    check("t6_grant", 32'(grant), 32'b0100);
    step();
    step();
    step();
    reset = 1'b1;
    #1;
    check("t6_rst_grant", 32'(grant), 32'b0);
    check("t6_rst_ack", 32'(ack), 32'b0);
    check("t6_rst_en", 32'({raid_read_en, raid_write_en}), 32'd0);
    req = 4'b1001;
    step();
    step();
    reset = 1'b0;
    wait_grant(20, n);
    check("t6_regrant", 32'(grant), 32'b0001);
    wait_ack(30, n);
    req = 4'b0;
    check("t6_ack", 32'(ack), 32'b0001);
    check("no_enable_overlap", 32'(ovl_cnt), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/raid_host_arbiter.md
Name: raid_host_arbiter

Overview:
- Shares the single host port of the RAID controller between NREQ independent requesters.
- Round-robin grant; one transaction in flight at a time.
- Sequences the controller handshake: one-cycle read/write enable pulse, wait for busy to rise, wait for busy to fall, settle, capture.
- Returns read data plus parity/err status to the granted requester with a one-cycle ack.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TO_CYCLES, 64, cycles to wait for controller busy to rise after the enable pulse before declaring a start timeout.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request level; held until ack.
- req_we  in  NREQ  per-requester op: 1=write, 0=read; stable while req high.
- req_addr  in  32*NREQ  packed addresses; slice i = [32i+31:32i].
- req_din  in  32*NREQ  packed write data.
- grant  out  NREQ  one-hot current owner; 0 when idle.
- ack  out  NREQ  one-hot one-cycle completion pulse.
- rsp_data  out  32  read data; undefined contents for writes.
- rsp_parity  out  1  controller parity flag captured at completion.
- rsp_err  out  1  controller err flag captured at completion.
- rsp_timeout  out  1  transaction aborted by start timeout; valid with ack.
- raid_read_en  out  1  controller read enable.
- raid_write_en  out  1  controller write enable.
- raid_addr  out  32  controller address.
- raid_din  out  32  controller write data.
- raid_dout  in  32  controller read data.
- raid_busy  in  1  controller busy.
- raid_parity  in  1  controller parity flag.
- raid_err  in  1  controller err flag.

Behaviour:
- Reset values:
  - grant = 0, ack = 0, rsp_* = 0, raid_read_en = 0, raid_write_en = 0, raid_addr = 0, raid_din = 0.
  - State = IDLE, round-robin pointer = 0, timeout counter = 0.
- State machine:
  - IDLE: when req != 0 and raid_busy == 0, pick the first set bit at or after the pointer, wrapping modulo NREQ. Register grant one-hot, latch raid_addr/raid_din from that slice, go to ISSUE. If raid_busy == 1, stay in IDLE. This covers the controller asserting busy out of reset.
  - ISSUE, one cycle: assert exactly one enable. raid_write_en = req_we[g], raid_read_en = !req_we[g]. Clear counter. Go to START.
  - START: enables are 0. If raid_busy == 1, go to RUN. Otherwise increment the counter. When counter == TO_CYCLES-1 with busy still 0, go to DONE with the timeout flag set.
  - RUN: wait for raid_busy == 0, then go to SETTLE.
  - SETTLE, one cycle: allows the controller's output register to update.
  - DONE, one cycle:
    - rsp_data <= raid_dout; rsp_parity <= raid_parity; rsp_err <= raid_err; rsp_timeout <= timeout flag.
    - ack[g] pulses.
    - Pointer <= g+1 mod NREQ. grant <= 0. Go to IDLE.
- Response outputs hold their value until the next DONE.
- Enable discipline: raid_read_en and raid_write_en are never both 1, and each is high only in ISSUE.
- raid_addr and raid_din stay stable from ISSUE through DONE.
- Latency: from ISSUE, ack comes at ISSUE + 1 + (cycles to busy rise) + (busy duration) + 2. The minimum is 5 cycles after grant.
- Requests:
  - A requester dropping req mid-transaction does not abort it; ack is still pulsed.
  - A new req from the same requester is re-arbitrated only after DONE, so back-to-back requests from one requester yield to others.
- Fairness: with all NREQ requesting continuously, grants cycle 0,1,...,NREQ-1,0. No requester waits more than NREQ-1 transactions.
- Simultaneous events:
  - A request arriving in the DONE cycle is seen in IDLE next cycle.
  - raid_busy rising in the same cycle the counter would expire counts as started, not timed out.
- Reset mid-operation: everything returns to reset values immediately. No ack is generated for the aborted transaction. Enables drop asynchronously.
- rsp_err mirrors the controller's sticky err; the arbiter does not clear it.

Test Plan:
- Single read: req=4'b0010, req_we=0, addr slice1=32'h10. Model busy high 3 cycles, raid_dout=32'hA5A5_0001. Expect grant=4'b0010, one raid_read_en pulse with raid_addr=32'h10, ack=4'b0010, rsp_data=32'hA5A5_0001, rsp_timeout=0.
- Single write: req0 with req_we=1, din=32'h0102_0304. Expect raid_write_en one cycle with raid_din=32'h0102_0304, raid_read_en held 0, ack[0] after busy falls + 2 cycles.
- Round robin: all four req high continuously with 2-cycle busy. Expect grant sequence 1,2,4,8,1 (one-hot), exactly one ack per transaction, and enables never overlapping.
- Busy at reset: raid_busy=1 for 10 cycles after reset release with req=4'b0001. Expect grant=0 until busy drops, then normal issue.
- Timeout: busy model never rises, TO_CYCLES=64. Expect ack[0] exactly 64 cycles after the ISSUE cycle+1, rsp_timeout=1, next requester served afterward.
- Reset mid-RUN: assert reset while busy=1. Expect grant, ack and enables all 0 immediately; after release, a pending req is re-served from pointer 0.
